// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: Moore FSM driving datapath enables
// and selects, with memory wait tracking, timeout fault and retire count.
// Ports:
//   clk, reset_n (sync, active-low)
//   instruction, alu_zero, mem_ready
//   pc_write, pc_src, iord, mem_read, mem_write, ir_write
//   reg_write, reg_dst, write_reg31, mem_to_reg, link
//   alu_src_a, alu_src_b, alu_op, ext_op
//   illegal_instr, instr_done, fault, retired
module multicycle_control #(
   parameter int MEM_TIMEOUT = 255,
   parameter int WAIT_W      = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instruction,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        write_reg31,
   output logic        mem_to_reg,
   output logic        link,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic        ext_op,
   output logic        illegal_instr,
   output logic        instr_done,
   output logic        fault,
   output logic [31:0] retired
);

   localparam logic [5:0] OPCODE_RTYPE = 6'h00;
   localparam logic [5:0] OPCODE_J     = 6'h02;
   localparam logic [5:0] OPCODE_JAL   = 6'h03;
   localparam logic [5:0] OPCODE_BEQ   = 6'h04;
   localparam logic [5:0] OPCODE_BNE   = 6'h05;
   localparam logic [5:0] OPCODE_ADDI  = 6'h08;
   localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
   localparam logic [5:0] OPCODE_ORI   = 6'h0D;
   localparam logic [5:0] OPCODE_LW    = 6'h23;
   localparam logic [5:0] OPCODE_SW    = 6'h2B;

   localparam logic [5:0] FUNC_SLL = 6'h00;
   localparam logic [5:0] FUNC_SRL = 6'h02;
   localparam logic [5:0] FUNC_JR  = 6'h08;
   localparam logic [5:0] FUNC_ADD = 6'h20;
   localparam logic [5:0] FUNC_SUB = 6'h22;
   localparam logic [5:0] FUNC_AND = 6'h24;
   localparam logic [5:0] FUNC_OR  = 6'h25;
   localparam logic [5:0] FUNC_NOR = 6'h27;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_NOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRL = 3'd6;

   localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXEC, S_ALUWB, S_IMMEXEC, S_IMMWB,
      S_BRANCH, S_JUMP, S_FAULT
   } state_t;

   state_t            state, state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic [31:0]       retired_q;

   logic [5:0] opcode, func;
   assign opcode = instruction[31:26];
   assign func   = instruction[5:0];

   logic op_rtype, r_alu, r_jr;
   logic is_ldst, is_imm, is_br, is_jmp;
   assign op_rtype = (opcode == OPCODE_RTYPE);
   assign r_alu = op_rtype &&
                  (func == FUNC_ADD || func == FUNC_SUB ||
                   func == FUNC_AND || func == FUNC_OR  ||
                   func == FUNC_NOR || func == FUNC_SLL ||
                   func == FUNC_SRL);
   assign r_jr    = op_rtype && (func == FUNC_JR);
   assign is_ldst = (opcode == OPCODE_LW) || (opcode == OPCODE_SW);
   assign is_imm  = (opcode == OPCODE_ADDI) ||
                    (opcode == OPCODE_ANDI) ||
                    (opcode == OPCODE_ORI);
   assign is_br   = (opcode == OPCODE_BEQ) || (opcode == OPCODE_BNE);
   assign is_jmp  = (opcode == OPCODE_J) || (opcode == OPCODE_JAL) || r_jr;

   logic in_mem, timeout;
   assign in_mem = (state == S_FETCH) || (state == S_MEMREAD) ||
                   (state == S_MEMWRITE);
   // mem_ready in the last allowed cycle still completes normally
   assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TMO_LAST) &&
                    !mem_ready;

   function automatic logic [2:0] alu_from_func(input logic [5:0] f);
      unique case (f)
         FUNC_SUB: return OP_SUB;
         FUNC_AND: return OP_AND;
         FUNC_OR:  return OP_OR;
         FUNC_NOR: return OP_NOR;
         FUNC_SLL: return OP_SLL;
         FUNC_SRL: return OP_SRL;
         default:  return OP_ADD;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_FETCH;
         wait_cnt  <= '0;
         retired_q <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            wait_cnt <= '0;
         else if (in_mem && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
         if (instr_done)
            retired_q <= retired_q + 32'd1;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_FETCH:
            if (mem_ready)    state_next = S_DECODE;
            else if (timeout) state_next = S_FAULT;
         S_DECODE:
            unique case (1'b1)
               is_ldst: state_next = S_MEMADDR;
               r_alu:   state_next = S_EXEC;
               is_jmp:  state_next = S_JUMP;
               is_imm:  state_next = S_IMMEXEC;
               is_br:   state_next = S_BRANCH;
               default: state_next = S_FETCH;
            endcase
         S_MEMADDR:
            state_next = (opcode == OPCODE_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:
            if (mem_ready)    state_next = S_MEMWB;
            else if (timeout) state_next = S_FAULT;
         S_MEMWRITE:
            if (mem_ready)    state_next = S_FETCH;
            else if (timeout) state_next = S_FAULT;
         S_EXEC:    state_next = S_ALUWB;
         S_IMMEXEC: state_next = S_IMMWB;
         S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP:
            state_next = S_FETCH;
         S_FAULT:   state_next = S_FAULT;
         default:   state_next = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      write_reg31   = 1'b0;
      mem_to_reg    = 1'b0;
      link          = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'd0;
      ext_op        = 1'b0;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
      fault         = 1'b0;
      if (reset_n) begin
         alu_op = OP_ADD;
         unique case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               ext_op    = 1'b1;
               if (!(is_ldst || r_alu || is_jmp || is_imm || is_br)) begin
                  illegal_instr = 1'b1;
                  instr_done    = 1'b1;
               end
            end
            S_MEMADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               ext_op    = 1'b1;
            end
            S_MEMREAD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWRITE: begin
               iord       = 1'b1;
               mem_write  = 1'b1;
               instr_done = mem_ready;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = alu_from_func(func);
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_IMMEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               unique case (1'b1)
                  (opcode == OPCODE_ANDI): alu_op = OP_AND;
                  (opcode == OPCODE_ORI):  alu_op = OP_OR;
                  default:                 ext_op = 1'b1;
               endcase
            end
            S_IMMWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = OP_SUB;
               pc_src     = 2'b01;
               pc_write   = (opcode == OPCODE_BNE) ? !alu_zero : alu_zero;
               instr_done = 1'b1;
            end
            S_JUMP: begin
               pc_write   = 1'b1;
               instr_done = 1'b1;
               pc_src     = r_jr ? 2'b11 : 2'b10;
               if (opcode == OPCODE_JAL) begin
                  reg_write   = 1'b1;
                  write_reg31 = 1'b1;
                  link        = 1'b1;
               end
            end
            S_FAULT: begin
               alu_op = 3'd0;
               fault  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign retired = reset_n ? retired_q : 32'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4).
// Each task walks one instruction scenario cycle by cycle.
module tb_multicycle_control;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_NOR = 3'd4;

   localparam logic [31:0] I_ADD = 32'h012A4020;
   localparam logic [31:0] I_NOR = 32'h012A4027;
   localparam logic [31:0] I_LW  = 32'h8D090004;
   localparam logic [31:0] I_SW  = 32'hAD090008;
   localparam logic [31:0] I_BEQ = 32'h11090003;
   localparam logic [31:0] I_BNE = 32'h15090003;
   localparam logic [31:0] I_JAL = 32'h0C000010;
   localparam logic [31:0] I_BAD = 32'hFC000000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] instruction;
   logic        alu_zero;
   logic        mem_ready;
   logic        pc_write, iord, mem_read, mem_write, ir_write;
   logic        reg_write, reg_dst, write_reg31, mem_to_reg, link;
   logic        alu_src_a, ext_op, illegal_instr, instr_done, fault;
   logic [1:0]  pc_src, alu_src_b;
   logic [2:0]  alu_op;
   logic [31:0] retired;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_ret;

   multicycle_control #(.MEM_TIMEOUT(4), .WAIT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .instruction(instruction),
      .alu_zero(alu_zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst),
      .write_reg31(write_reg31), .mem_to_reg(mem_to_reg), .link(link),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .ext_op(ext_op), .illegal_instr(illegal_instr),
      .instr_done(instr_done), .fault(fault), .retired(retired)
   );

   always #5 clk = ~clk;

   wire [21:0] outs = {pc_write, pc_src, iord, mem_read, mem_write,
                       ir_write, reg_write, reg_dst, write_reg31,
                       mem_to_reg, link, alu_src_a, alu_src_b, alu_op,
                       ext_op, illegal_instr, instr_done, fault};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      mem_ready = 1'b1;
      alu_zero = 1'b0;
      instruction = I_ADD;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (outs !== 22'h0 || retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_outs got=%h/%h exp=0/0", outs, retired);
         end
      end
      reset_n = 1'b1;
      #1;
      total++;
      if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b11101 ||
          retired !== 32'd0) begin
         bad++;
         $display("FAIL reset_release got=%b ret=%0d exp=11101 ret=0",
                  {mem_read, ir_write, pc_write, alu_src_b}, retired);
      end
      exp_ret = 32'd0;
   endtask

   task automatic test_add;
      instruction = I_ADD;
      mem_ready = 1'b1;
      tick();
      total++;
      if ({alu_src_a, alu_src_b, ext_op, mem_read} !== 5'b01110) begin
         bad++;
         $display("FAIL add_decode got=%b exp=01110",
                  {alu_src_a, alu_src_b, ext_op, mem_read});
      end
      tick();
      total++;
      if ({alu_src_a, alu_src_b, alu_op, reg_write} !== {3'b100, OP_ADD, 1'b0}) begin
         bad++;
         $display("FAIL add_exec got=%b exp=%b",
                  {alu_src_a, alu_src_b, alu_op, reg_write}, {3'b100, OP_ADD, 1'b0});
      end
      tick();
      total++;
      if ({reg_write, reg_dst, instr_done} !== 3'b101 || retired !== exp_ret) begin
         bad++;
         $display("FAIL add_wb got=%b ret=%0d exp=101 ret=%0d",
                  {reg_write, reg_dst, instr_done}, retired, exp_ret);
      end
      tick();
      exp_ret = exp_ret + 1;
      total++;
      if (retired !== exp_ret || mem_read !== 1'b1) begin
         bad++;
         $display("FAIL add_retire got=%0d rd=%b exp=%0d rd=1",
                  retired, mem_read, exp_ret);
      end
   endtask

   task automatic test_nor;
      instruction = I_NOR;
      tick();
      tick();
      total++;
      if (alu_op !== OP_NOR || alu_src_a !== 1'b1) begin
         bad++;
         $display("FAIL nor_exec got=%0d exp=%0d", alu_op, OP_NOR);
      end
      tick();
      tick();
      exp_ret = exp_ret + 1;
   endtask

   task automatic test_lw_wait;
      int n;
      instruction = I_LW;
      mem_ready = 1'b1;
      n = 1;
      tick();
      tick();
      n += 2;
      total++;
      if ({alu_src_a, alu_src_b, ext_op} !== 4'b1101) begin
         bad++;
         $display("FAIL lw_addr got=%b exp=1101",
                  {alu_src_a, alu_src_b, ext_op});
      end
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n++;
         if (i == 3) mem_ready = 1'b1;
         #1;
         total++;
         if ({iord, mem_read, instr_done, fault} !== 4'b1100) begin
            bad++;
            $display("FAIL lw_memread%0d got=%b exp=1100", i,
                     {iord, mem_read, instr_done, fault});
         end
      end
      tick();
      n++;
      total++;
      if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1111) begin
         bad++;
         $display("FAIL lw_wb got=%b exp=1111",
                  {reg_write, reg_dst, mem_to_reg, instr_done});
      end
      tick();
      exp_ret = exp_ret + 1;
      total++;
      if (n !== 8 || retired !== exp_ret || mem_read !== 1'b1) begin
         bad++;
         $display("FAIL lw_latency got=%0d ret=%0d exp=8 ret=%0d",
                  n, retired, exp_ret);
      end
   endtask

   task automatic test_branch;
      alu_zero = 1'b1;
      instruction = I_BEQ;
      tick();
      tick();
      total++;
      if ({pc_write, pc_src, alu_op, alu_src_a, instr_done} !==
          {3'b101, OP_SUB, 2'b11}) begin
         bad++;
         $display("FAIL beq_taken got=%b exp=%b",
                  {pc_write, pc_src, alu_op, alu_src_a, instr_done},
                  {3'b101, OP_SUB, 2'b11});
      end
      tick();
      exp_ret = exp_ret + 1;
      instruction = I_BNE;
      tick();
      tick();
      total++;
      if ({pc_write, pc_src, instr_done} !== 4'b0011) begin
         bad++;
         $display("FAIL bne_zero got=%b exp=0011",
                  {pc_write, pc_src, instr_done});
      end
      alu_zero = 1'b0;
      #1;
      total++;
      if (pc_write !== 1'b1) begin
         bad++;
         $display("FAIL bne_nonzero got=%b exp=1", pc_write);
      end
      tick();
      exp_ret = exp_ret + 1;
      total++;
      if (retired !== exp_ret || mem_read !== 1'b1) begin
         bad++;
         $display("FAIL branch_retire got=%0d exp=%0d", retired, exp_ret);
      end
   endtask

   task automatic test_jal_fetch_boundary;
      instruction = I_JAL;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      mem_ready = 1'b1;
      #1;
      total++;
      if ({ir_write, pc_write, fault} !== 3'b110) begin
         bad++;
         $display("FAIL fetch_last_ready got=%b exp=110",
                  {ir_write, pc_write, fault});
      end
      tick();
      tick();
      total++;
      if ({pc_write, pc_src, reg_write, write_reg31, link, instr_done} !==
          7'b1101111) begin
         bad++;
         $display("FAIL jal_jump got=%b exp=1101111",
                  {pc_write, pc_src, reg_write, write_reg31, link, instr_done});
      end
      tick();
      exp_ret = exp_ret + 1;
   endtask

   task automatic test_illegal;
      instruction = I_BAD;
      tick();
      total++;
      if ({illegal_instr, instr_done, reg_write} !== 3'b110) begin
         bad++;
         $display("FAIL illegal_decode got=%b exp=110",
                  {illegal_instr, instr_done, reg_write});
      end
      tick();
      exp_ret = exp_ret + 1;
      total++;
      if (retired !== exp_ret || illegal_instr !== 1'b0 || mem_read !== 1'b1) begin
         bad++;
         $display("FAIL illegal_retire got=%0d ill=%b exp=%0d ill=0",
                  retired, illegal_instr, exp_ret);
      end
   endtask

   task automatic test_sw_reset;
      instruction = I_SW;
      mem_ready = 1'b1;
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      total++;
      if ({iord, mem_write, instr_done} !== 3'b110) begin
         bad++;
         $display("FAIL sw_write got=%b exp=110",
                  {iord, mem_write, instr_done});
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (outs !== 22'h0 || retired !== 32'd0) begin
         bad++;
         $display("FAIL sw_reset_force got=%h ret=%0d exp=0 ret=0",
                  outs, retired);
      end
      tick();
      reset_n = 1'b1;
      #1;
      exp_ret = 32'd0;
      total++;
      if ({mem_read, ir_write, mem_write} !== 3'b100 || retired !== exp_ret) begin
         bad++;
         $display("FAIL sw_reset_fetch got=%b ret=%0d exp=100 ret=0",
                  {mem_read, ir_write, mem_write}, retired);
      end
   endtask

   task automatic test_timeout;
      // already in cycle 1 of a stalled fetch
      for (int i = 1; i <= 4; i++) begin
         total++;
         if ({mem_read, fault} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_wait%0d got=%b exp=10", i, {mem_read, fault});
         end
         tick();
      end
      total++;
      if (outs !== 22'h1 || retired !== exp_ret) begin
         bad++;
         $display("FAIL timeout_fault got=%h ret=%0d exp=000001 ret=%0d",
                   outs, retired, exp_ret);
      end
      mem_ready = 1'b1;
      tick();
      total++;
      if (outs !== 22'h1) begin
         bad++;
         $display("FAIL fault_sticky got=%h exp=000001", outs);
      end
   endtask

   task automatic test_reset_recover;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      total++;
      if ({fault, mem_read, ir_write} !== 3'b011) begin
         bad++;
         $display("FAIL recover got=%b exp=011", {fault, mem_read, ir_write});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_nor();
      test_lw_wait();
      test_branch();
      test_jal_fetch_boundary();
      test_illegal();
      test_sw_reset();
      test_timeout();
      test_reset_recover();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencer for the multicycle MIPS datapath: one instruction spans several clocks, and a single shared instruction/data memory is accessed over a ready handshake.
- Drives PC/IR write enables, datapath mux selects, ALU op and register-file writes.
- Tracks memory wait cycles, faults on timeout, and counts retired instructions.
- Opcode, func and ALU-op encodings come from _const.v (`OPCODE_*`, `FUNC_*`, `OP_*`).

Parameters:
MEM_TIMEOUT, 255, number of consecutive not-ready cycles in a memory state before fault; 0 disables the timeout.
WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous reset, active-low
instruction  in  32  IR contents (valid from DECODE onward)
alu_zero  in  1  ALU zero flag, current cycle
mem_ready  in  1  shared memory completes the access this cycle
pc_write  out  1  PC load enable
pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target {PC[31:28],imm26,00}, 11=rs
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_write  out  1  register file write enable
reg_dst  out  1  destination: 0=rd, 1=rt
write_reg31  out  1  destination forced to $31
mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut/link
link  out  1  writeback source is PC (already PC+4)
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=ext(imm), 11=sext(imm)<<2
alu_op  out  3  `OP_*` code
ext_op  out  1  1=sign-extend imm, 0=zero-extend
illegal_instr  out  1  one-cycle pulse: unsupported opcode/func
instr_done  out  1  one-cycle pulse in the final cycle of an instruction
fault  out  1  memory timeout; sticky until reset
retired  out  32  count of completed instructions

Behaviour:
- Reset (reset_n=0 at posedge): state<=FETCH, wait counter<=0, retired<=0, fault<=0.
- While reset_n=0, every output is forced to 0 combinationally, including mem_write. Reset mid-access abandons the access.
- Defaults in every state: all enables 0, selects 0, alu_op=`OP_ADD`. Only the deviations below are asserted.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=00 (same cycle), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=1 (branch target latched into ALUOut). Next state by opcode:
  - LW/SW -> MEMADDR
  - RTYPE with func ADD/SUB/AND/OR/NOR/SLL/SRL -> EXEC
  - RTYPE JR -> JUMP
  - ADDI/ANDI/ORI -> IMMEXEC
  - BEQ/BNE -> BRANCH
  - J/JAL -> JUMP
  - anything else: illegal_instr=1, instr_done=1, next FETCH (treated as NOP).
- MEMADDR: alu_src_a=1, alu_src_b=10, ext_op=1. Next MEMREAD (LW) or MEMWRITE (SW).
- MEMREAD: iord=1, mem_read=1. On mem_ready -> MEMWB.
- MEMWB: reg_write=1, reg_dst=1, mem_to_reg=1, instr_done=1. Next FETCH.
- MEMWRITE: iord=1, mem_write=1. On mem_ready: instr_done=1, next FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op from func. Next ALUWB.
- ALUWB: reg_write=1, reg_dst=0, instr_done=1. Next FETCH.
- IMMEXEC: alu_src_a=1, alu_src_b=10.
  - ADDI: ext_op=1, `OP_ADD`. ANDI: ext_op=0, `OP_AND`. ORI: ext_op=0, `OP_OR`.
  - Next IMMWB.
- IMMWB: reg_write=1, reg_dst=1, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, `OP_SUB`, pc_src=01.
  - pc_write = alu_zero for BEQ, ~alu_zero for BNE.
  - instr_done=1. Next FETCH.
- JUMP: pc_write=1, instr_done=1. Next FETCH.
  - J/JAL: pc_src=10. JR: pc_src=11.
  - JAL additionally: reg_write=1, write_reg31=1, link=1.
- FAULT: all outputs 0 except fault=1. Stays in FAULT until reset.
- Wait counter (memory states FETCH, MEMREAD, MEMWRITE):
  - Cleared on entry to any memory state; increments each cycle with mem_ready=0.
  - If counter==MEM_TIMEOUT-1 and mem_ready=0, next state is FAULT.
  - mem_ready=1 in that same cycle wins: normal transition, no fault.
- retired increments at the posedge ending any instr_done cycle, including illegal NOPs. Wraps 0xFFFFFFFF->0.
- Zero-wait latencies: branch/jump 3 cycles; R-type/imm/SW 4; LW 5.

Test Plan:
- Reset held 2 cycles, release with mem_ready=1 -> all outputs 0 during reset; first cycle after release mem_read=1, ir_write=1, pc_write=1; retired=0.
- ADD R-type, mem_ready tied 1 -> states FETCH, DECODE, EXEC, ALUWB; alu_op=`OP_ADD` in EXEC; reg_write=1, reg_dst=0 in ALUWB; retired 0->1 after 4 cycles.
- LW with mem_ready low 3 cycles in MEMREAD -> stays in MEMREAD for 4 cycles, then MEMWB with mem_to_reg=1, reg_dst=1; total 8 cycles.
- BEQ with alu_zero=1, then BNE with alu_zero=1 -> BEQ: pc_write=1, pc_src=01; BNE: pc_write=0; each 3 cycles.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> fault=1 on cycle 5, outputs 0, retired frozen. Repeat with mem_ready=1 on the 4th cycle -> no fault.
- Opcode 6'h3F -> illegal_instr pulse in DECODE, retired+1, back to FETCH. JAL -> reg_write=1, write_reg31=1, link=1, pc_src=10.
